// File: rtl/mixer_sequencer_if.sv
// rtl/mixer_sequencer_if.sv - oscillator handshake and mixer sample bus between sequencer and datapath
interface mixer_sequencer_if;
    logic       osc_1_req;
    logic       osc_2_req;
    logic       osc_1_ack;
    logic       osc_2_ack;
    logic [7:0] osc_1_data;
    logic [7:0] osc_2_data;
    logic [7:0] sample;
    logic       sample_1_load;
    logic       sample_2_load;
    logic       execute;
    logic       frame_done;

    modport master (
        output osc_1_req,
        output osc_2_req,
        input  osc_1_ack,
        input  osc_2_ack,
        input  osc_1_data,
        input  osc_2_data,
        output sample,
        output sample_1_load,
        output sample_2_load,
        output execute,
        output frame_done
    );

    modport slave (
        input  osc_1_req,
        input  osc_2_req,
        output osc_1_ack,
        output osc_2_ack,
        output osc_1_data,
        output osc_2_data,
        input  sample,
        input  sample_1_load,
        input  sample_2_load,
        input  execute,
        input  frame_done
    );
endinterface

// File: rtl/mixer_sequencer.sv
// rtl/mixer_sequencer.sv - per-tick frame sequencer: fetch two oscillator samples, load mixer, execute
module mixer_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic              clear_flags,
    input  logic [2:0]        level_1,
    input  logic [2:0]        level_2,
    output logic [2:0]        sample_1_level,
    output logic [2:0]        sample_2_level,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_1,
    output logic              timeout_2,
    mixer_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        LOAD1 = 3'd2,
        REQ2  = 3'd3,
        LOAD2 = 3'd4,
        EXEC  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [2:0] LEVEL_MAX   = 3'd5;

    state_t     state;
    state_t     state_n;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_n;
    logic [7:0] hold_1;
    logic [7:0] hold_1_n;
    logic [7:0] hold_2;
    logic [7:0] hold_2_n;
    logic       accept;
    logic       set_overrun;
    logic       set_timeout_1;
    logic       set_timeout_2;

    function automatic logic [2:0] clamp_level(input logic [2:0] level);
        return (level > LEVEL_MAX) ? LEVEL_MAX : level;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        wait_cnt_n    = wait_cnt;
        hold_1_n      = hold_1;
        hold_2_n      = hold_2;
        accept        = 1'b0;
        set_timeout_1 = 1'b0;
        set_timeout_2 = 1'b0;
        // Ticks while a frame is in flight are dropped and only flagged.
        set_overrun   = enable && sample_tick && (state != IDLE);

        case (state)
            IDLE: begin
                if (enable && sample_tick) begin
                    accept     = 1'b1;
                    wait_cnt_n = 8'd0;
                    state_n    = REQ1;
                end
            end
            REQ1: begin
                if (bus.osc_1_ack) begin
                    hold_1_n = bus.osc_1_data;
                    state_n  = LOAD1;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    set_timeout_1 = 1'b1;
                    state_n       = LOAD1;
                end else if (wait_cnt < TIMEOUT_CNT) begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            LOAD1: begin
                wait_cnt_n = 8'd0;
                state_n    = REQ2;
            end
            REQ2: begin
                if (bus.osc_2_ack) begin
                    hold_2_n = bus.osc_2_data;
                    state_n  = LOAD2;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    set_timeout_2 = 1'b1;
                    state_n       = LOAD2;
                end else if (wait_cnt < TIMEOUT_CNT) begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            LOAD2:   state_n = EXEC;
            EXEC:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every strobe is a clean register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt          <= 8'd0;
            hold_1            <= 8'd0;
            hold_2            <= 8'd0;
            bus.osc_1_req     <= 1'b0;
            bus.osc_2_req     <= 1'b0;
            bus.sample        <= 8'd0;
            bus.sample_1_load <= 1'b0;
            bus.sample_2_load <= 1'b0;
            bus.execute       <= 1'b0;
            bus.frame_done    <= 1'b0;
            busy              <= 1'b0;
            sample_1_level    <= 3'd0;
            sample_2_level    <= 3'd0;
            overrun           <= 1'b0;
            timeout_1         <= 1'b0;
            timeout_2         <= 1'b0;
        end else begin
            wait_cnt          <= wait_cnt_n;
            hold_1            <= hold_1_n;
            hold_2            <= hold_2_n;
            bus.osc_1_req     <= (state_n == REQ1);
            bus.osc_2_req     <= (state_n == REQ2);
            bus.sample_1_load <= (state_n == LOAD1);
            bus.sample_2_load <= (state_n == LOAD2);
            bus.execute       <= (state_n == EXEC);
            bus.frame_done    <= (state_n == DONE);
            busy              <= (state_n != IDLE);

            if (state_n == LOAD1) begin
                bus.sample <= hold_1_n;
            end else if (state_n == LOAD2) begin
                bus.sample <= hold_2_n;
            end

            if (accept) begin
                sample_1_level <= clamp_level(level_1);
                sample_2_level <= clamp_level(level_2);
            end

            // A set in the same cycle as a clear takes priority.
            overrun   <= set_overrun   | (overrun   & ~clear_flags);
            timeout_1 <= set_timeout_1 | (timeout_1 & ~clear_flags);
            timeout_2 <= set_timeout_2 | (timeout_2 & ~clear_flags);
        end
    end

endmodule
